// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcode class, ALU op and instruction pointer constants
package proc_pkg;

    localparam int OPCODE_WIDTH     = 8;
    localparam int ALU_OPCODE_WIDTH = 3;

    typedef enum logic [4:0] {
        CLS_NOP         = 5'b00000,
        CLS_PULSE       = 5'b00001,
        CLS_REG_ALU_I   = 5'b00010,
        CLS_REG_ALU     = 5'b00011,
        CLS_JUMP_I      = 5'b00100,
        CLS_JUMP_COND_I = 5'b00101,
        CLS_JUMP_COND   = 5'b00110,
        CLS_ALU_QCLK_I  = 5'b00111,
        CLS_ALU_QCLK    = 5'b01000,
        CLS_SYNC        = 5'b01001,
        CLS_FPROC       = 5'b01010
    } opclass_t;

    typedef enum logic [ALU_OPCODE_WIDTH-1:0] {
        ALU_ID0  = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_EQ   = 3'b011,
        ALU_LT   = 3'b100,
        ALU_GT   = 3'b101,
        ALU_ZERO = 3'b110,
        ALU_ID1  = 3'b111
    } alu_op_t;

    localparam logic [1:0] INST_PTR_DEFAULT_EN = 2'b00;
    localparam logic [1:0] INST_PTR_SYNC_EN    = 2'b01;
    localparam logic [1:0] INST_PTR_FPROC_EN   = 2'b10;

    localparam logic [1:0] INST_PTR_NO_LOAD   = 2'b00;
    localparam logic [1:0] INST_PTR_LOAD      = 2'b01;
    localparam logic [1:0] INST_PTR_LOAD_COND = 2'b10;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU, zero-extended results, wrapping add/sub
module alu
    import proc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [ALU_OPCODE_WIDTH-1:0] i_op,
    input  logic [DATA_WIDTH-1:0]       i_in0,
    input  logic [DATA_WIDTH-1:0]       i_in1,
    output logic [DATA_WIDTH-1:0]       o_out
);

    always_comb begin
        o_out = '0;
        case (i_op)
            ALU_ID0:  o_out = i_in0;
            ALU_ADD:  o_out = i_in0 + i_in1;
            ALU_SUB:  o_out = i_in0 - i_in1;
            ALU_EQ:   o_out = DATA_WIDTH'(i_in0 == i_in1);
            ALU_LT:   o_out = DATA_WIDTH'($signed(i_in0) < $signed(i_in1));
            ALU_GT:   o_out = DATA_WIDTH'($signed(i_in0) > $signed(i_in1));
            ALU_ZERO: o_out = '0;
            ALU_ID1:  o_out = i_in1;
            default:  o_out = '0;
        endcase
    end

endmodule

// File: rtl/cmd_mem.sv
// rtl/cmd_mem.sv - program command RAM with registered read port
// CMD_MEM_WRITE_FIRST_EN selects write-first same-address behaviour; read-first otherwise.
module cmd_mem #(
    parameter int CMD_WIDTH      = 128,
    parameter int CMD_ADDR_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_we,
    input  logic [CMD_ADDR_WIDTH-1:0] i_waddr,
    input  logic [CMD_WIDTH-1:0]      i_wdata,
    input  logic [CMD_ADDR_WIDTH-1:0] i_raddr,
    output logic [CMD_WIDTH-1:0]      o_rdata
);

    localparam int DEPTH = 2 ** CMD_ADDR_WIDTH;

    logic [CMD_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [CMD_WIDTH-1:0] r_rdata;
    logic [CMD_WIDTH-1:0] w_rd_data;

    // Memory is never reset, so a write during reset still lands.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

`ifdef CMD_MEM_WRITE_FIRST_EN
    assign w_rd_data = (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
`else
    assign w_rd_data = r_mem[i_raddr];
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rd_data;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cmd_alu_ctrl.sv
// rtl/cmd_alu_ctrl.sv - command memory, opcode decode and ALU execution slice
// Same-address read/write behaviour is selected by CMD_MEM_WRITE_FIRST_EN (see cmd_mem).
module cmd_alu_ctrl
    import proc_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_WIDTH      = 128,
    parameter int CMD_ADDR_WIDTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_write_prog_enable,
    input  logic [CMD_ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [CMD_WIDTH-1:0]        i_cmd_data,
    input  logic [CMD_ADDR_WIDTH-1:0]   i_read_address,
    output logic [CMD_WIDTH-1:0]        o_cmd_out,
    input  logic [DATA_WIDTH-1:0]       i_alu_in0,
    input  logic [DATA_WIDTH-1:0]       i_alu_in1,
    output logic [DATA_WIDTH-1:0]       o_alu_out,
    output logic [ALU_OPCODE_WIDTH-1:0] o_alu_opcode,
    output logic                        o_c_strobe_enable,
    output logic                        o_alu_in0_sel,
    output logic                        o_alu_in1_sel,
    output logic                        o_reg_write_en,
    output logic                        o_qclk_load_en,
    output logic [1:0]                  o_instr_ptr_en_sel,
    output logic [1:0]                  o_instr_ptr_load_en,
    output logic                        o_sync_out_ready,
    output logic                        o_fproc_out_ready
);

    logic [OPCODE_WIDTH-1:0]     w_opcode;
    logic [4:0]                  w_class;
    logic [ALU_OPCODE_WIDTH-1:0] w_alu_op;

    cmd_mem #(
        .CMD_WIDTH      (CMD_WIDTH),
        .CMD_ADDR_WIDTH (CMD_ADDR_WIDTH)
    ) u_cmd_mem (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (i_write_prog_enable),
        .i_waddr (i_cmd_addr),
        .i_wdata (i_cmd_data),
        .i_raddr (i_read_address),
        .o_rdata (o_cmd_out)
    );

    assign w_opcode = o_cmd_out[CMD_WIDTH-1 -: OPCODE_WIDTH];
    assign w_class  = w_opcode[OPCODE_WIDTH-1:ALU_OPCODE_WIDTH];
    assign w_alu_op = w_opcode[ALU_OPCODE_WIDTH-1:0];

    // Only classes that consume an ALU result forward the op; the rest see ALU_ID0.
    always_comb begin
        o_alu_opcode        = ALU_ID0;
        o_c_strobe_enable   = 1'b0;
        o_alu_in0_sel       = 1'b0;
        o_alu_in1_sel       = 1'b0;
        o_reg_write_en      = 1'b0;
        o_qclk_load_en      = 1'b0;
        o_instr_ptr_en_sel  = INST_PTR_DEFAULT_EN;
        o_instr_ptr_load_en = INST_PTR_NO_LOAD;
        o_sync_out_ready    = 1'b0;
        o_fproc_out_ready   = 1'b0;
        case (w_class)
            CLS_PULSE: o_c_strobe_enable = 1'b1;
            CLS_REG_ALU_I: begin
                o_alu_opcode   = w_alu_op;
                o_alu_in1_sel  = 1'b1;
                o_reg_write_en = 1'b1;
            end
            CLS_REG_ALU: begin
                o_alu_opcode   = w_alu_op;
                o_alu_in0_sel  = 1'b1;
                o_alu_in1_sel  = 1'b1;
                o_reg_write_en = 1'b1;
            end
            CLS_JUMP_I: o_instr_ptr_load_en = INST_PTR_LOAD;
            CLS_JUMP_COND_I: begin
                o_alu_opcode        = w_alu_op;
                o_alu_in1_sel       = 1'b1;
                o_instr_ptr_load_en = INST_PTR_LOAD_COND;
            end
            CLS_JUMP_COND: begin
                o_alu_opcode        = w_alu_op;
                o_alu_in0_sel       = 1'b1;
                o_alu_in1_sel       = 1'b1;
                o_instr_ptr_load_en = INST_PTR_LOAD_COND;
            end
            CLS_ALU_QCLK_I: begin
                o_alu_opcode   = w_alu_op;
                o_qclk_load_en = 1'b1;
            end
            CLS_ALU_QCLK: begin
                o_alu_opcode   = w_alu_op;
                o_alu_in0_sel  = 1'b1;
                o_qclk_load_en = 1'b1;
            end
            CLS_SYNC: begin
                o_instr_ptr_en_sel = INST_PTR_SYNC_EN;
                o_sync_out_ready   = 1'b1;
            end
            CLS_FPROC: begin
                o_instr_ptr_en_sel = INST_PTR_FPROC_EN;
                o_fproc_out_ready  = 1'b1;
            end
            default: ;
        endcase
    end

    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .i_op  (o_alu_opcode),
        .i_in0 (i_alu_in0),
        .i_in1 (i_alu_in1),
        .o_out (o_alu_out)
    );

endmodule

// File: tb/tb_cmd_alu_ctrl.sv
// tb/tb_cmd_alu_ctrl.sv - self-checking bench for cmd_alu_ctrl
module tb_cmd_alu_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         wpe;
    logic [7:0]   cmd_addr;
    logic [127:0] cmd_data;
    logic [7:0]   read_address;
    logic [127:0] cmd_out;
    logic [31:0]  alu_in0, alu_in1, alu_out;
    logic [2:0]   alu_opcode;
    logic         c_strobe, in0_sel, in1_sel, reg_we, qclk_en, sync_rdy, fproc_rdy;
    logic [1:0]   en_sel, load_en;
    logic [13:0]  ctrl;

    always #5 clk = ~clk;

    cmd_alu_ctrl dut (
        .i_clk               (clk),
        .i_reset             (reset),
        .i_write_prog_enable (wpe),
        .i_cmd_addr          (cmd_addr),
        .i_cmd_data          (cmd_data),
        .i_read_address      (read_address),
        .o_cmd_out           (cmd_out),
        .i_alu_in0           (alu_in0),
        .i_alu_in1           (alu_in1),
        .o_alu_out           (alu_out),
        .o_alu_opcode        (alu_opcode),
        .o_c_strobe_enable   (c_strobe),
        .o_alu_in0_sel       (in0_sel),
        .o_alu_in1_sel       (in1_sel),
        .o_reg_write_en      (reg_we),
        .o_qclk_load_en      (qclk_en),
        .o_instr_ptr_en_sel  (en_sel),
        .o_instr_ptr_load_en (load_en),
        .o_sync_out_ready    (sync_rdy),
        .o_fproc_out_ready   (fproc_rdy)
    );

    // {alu_opcode, strobe, in0_sel, in1_sel, reg_we, qclk, en_sel, load_en, sync, fproc}
    assign ctrl = {alu_opcode, c_strobe, in0_sel, in1_sel, reg_we, qclk_en,
                   en_sel, load_en, sync_rdy, fproc_rdy};

`ifdef CMD_MEM_WRITE_FIRST_EN
    localparam bit WRITE_FIRST = 1'b1;
`else
    localparam bit WRITE_FIRST = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] sh [0:255];
    logic [127:0] exp_cmd;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] in0;
        logic [31:0] in1;
        logic [31:0] exp_alu;
        logic [13:0] exp_ctrl;
    } vec_t;
    vec_t tv [18];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] ref_ctrl(input logic [7:0] op);
        logic [13:0] c;
        int cls;
        c   = '0;
        cls = int'(op) / 8;
        if (cls == 1)               c[10] = 1'b1;
        if (cls == 3 || cls == 6 || cls == 8)            c[9] = 1'b1;
        if (cls == 2 || cls == 3 || cls == 5 || cls == 6) c[8] = 1'b1;
        if (cls == 2 || cls == 3)   c[7] = 1'b1;
        if (cls == 7 || cls == 8)   c[6] = 1'b1;
        if (cls == 9)               c[5:4] = 2'b01;
        if (cls == 10)              c[5:4] = 2'b10;
        if (cls == 4)               c[3:2] = 2'b01;
        if (cls == 5 || cls == 6)   c[3:2] = 2'b10;
        if (cls == 9)               c[1] = 1'b1;
        if (cls == 10)              c[0] = 1'b1;
        if (cls == 2 || cls == 3 || (cls >= 5 && cls <= 8)) c[13:11] = op[2:0];
        return c;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: return a;
            3'd1: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
            3'd2: return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
            3'd3: return (a == b) ? 32'd1 : 32'd0;
            3'd4: return (sa < sb) ? 32'd1 : 32'd0;
            3'd5: return (sa > sb) ? 32'd1 : 32'd0;
            3'd6: return 32'd0;
            default: return b;
        endcase
    endfunction

    task automatic step(input logic rst, input logic we, input logic [7:0] wa, input logic [127:0] wd,
                        input logic [7:0] ra, input logic [31:0] a, input logic [31:0] b);
        reset = rst; wpe = we; cmd_addr = wa; cmd_data = wd; read_address = ra;
        alu_in0 = a; alu_in1 = b;
        if (rst)                               exp_cmd = '0;
        else if (we && wa == ra && WRITE_FIRST) exp_cmd = wd;
        else                                   exp_cmd = sh[ra];
        if (we) sh[wa] = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        logic [13:0] c;
        c = ref_ctrl(exp_cmd[127:120]);
        chk({tag, ".cmd_out"}, cmd_out, exp_cmd);
        chk({tag, ".ctrl"}, 128'(ctrl), 128'(c));
        chk({tag, ".alu_out"}, 128'(alu_out), 128'(ref_alu(c[13:11], alu_in0, alu_in1)));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [127:0] wd, d_rst;
        logic [31:0]  a, b;
        logic [7:0]   op;

        tv[0]  = '{8'h11, 32'hFFFF_FFFF, 32'h2,         32'h1,         14'b001_0_0_1_1_0_00_00_0_0};
        tv[1]  = '{8'h12, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFD, 14'b010_0_0_1_1_0_00_00_0_0};
        tv[2]  = '{8'h14, 32'hFFFF_FFFF, 32'h2,         32'h1,         14'b100_0_0_1_1_0_00_00_0_0};
        tv[3]  = '{8'h15, 32'hFFFF_FFFF, 32'h2,         32'h0,         14'b101_0_0_1_1_0_00_00_0_0};
        tv[4]  = '{8'h13, 32'hFFFF_FFFF, 32'h2,         32'h0,         14'b011_0_0_1_1_0_00_00_0_0};
        tv[5]  = '{8'h20, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 14'b000_0_0_0_0_0_00_01_0_0};
        tv[6]  = '{8'h2B, 32'h7,         32'h7,         32'h1,         14'b011_0_0_1_0_0_00_10_0_0};
        tv[7]  = '{8'h48, 32'h5,         32'h6,         32'h5,         14'b000_0_0_0_0_0_01_00_1_0};
        tv[8]  = '{8'h50, 32'h5,         32'h6,         32'h5,         14'b000_0_0_0_0_0_10_00_0_1};
        tv[9]  = '{8'hF8, 32'h0,         32'h6,         32'h0,         14'b000_0_0_0_0_0_00_00_0_0};
        tv[10] = '{8'h08, 32'h9,         32'h6,         32'h9,         14'b000_1_0_0_0_0_00_00_0_0};
        tv[11] = '{8'h1E, 32'h9,         32'h6,         32'h0,         14'b110_0_1_1_1_0_00_00_0_0};
        tv[12] = '{8'h3F, 32'h9,         32'h1234,      32'h1234,      14'b111_0_0_0_0_1_00_00_0_0};
        tv[13] = '{8'h40, 32'hABCD,      32'h1,         32'hABCD,      14'b000_0_1_0_0_1_00_00_0_0};
        tv[14] = '{8'h34, 32'h8000_0000, 32'h1,         32'h1,         14'b100_0_1_1_0_0_00_10_0_0};
        tv[15] = '{8'h2D, 32'h1,         32'h8000_0000, 32'h1,         14'b101_0_0_1_0_0_00_10_0_0};
        tv[16] = '{8'h09, 32'h3,         32'h4,         32'h3,         14'b000_1_0_0_0_0_00_00_0_0};
        tv[17] = '{8'h58, 32'h0,         32'h4,         32'h0,         14'b000_0_0_0_0_0_00_00_0_0};

        for (int i = 0; i < 256; i++) sh[i] = '0;

        step(1, 0, 0, '0, 0, 0, 0);
        step(1, 0, 0, '0, 0, 0, 0);
        chk("reset.cmd_out", cmd_out, 128'h0);
        chk("reset.ctrl", 128'(ctrl), 128'h0);

        for (int i = 0; i < 256; i++)
            step(0, 1, 8'(i), {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0);

        // Program write then read back with one-cycle latency.
        step(0, 1, 8'd5, {8'h11, 120'h0}, 8'd9, 0, 0);
        step(0, 0, 0, '0, 8'd5, 32'hFFFF_FFFF, 32'h2);
        chk("plan.cmd_out", cmd_out, {8'h11, 120'h0});
        chk("plan.alu_opcode", 128'(alu_opcode), 128'd1);
        chk("plan.in1_sel", 128'(in1_sel), 128'd1);
        chk("plan.reg_we", 128'(reg_we), 128'd1);
        chk("plan.alu_out", 128'(alu_out), 128'd1);

        for (int i = 0; i < 18; i++) begin
            wd = {tv[i].op, $urandom, $urandom, $urandom, 24'($urandom)};
            step(0, 1, 8'(8'h40 + i), wd, 8'd0, 0, 0);
            step(0, 0, 0, '0, 8'(8'h40 + i), tv[i].in0, tv[i].in1);
            chk($sformatf("tv%0d.cmd_out", i), cmd_out, wd);
            chk($sformatf("tv%0d.ctrl", i), 128'(ctrl), 128'(tv[i].exp_ctrl));
            chk($sformatf("tv%0d.alu_out", i), 128'(alu_out), 128'(tv[i].exp_alu));
        end

        // Reset with a live non-zero command and a concurrent write.
        step(0, 0, 0, '0, 8'h40, 32'h1, 32'h2);
        check_model("pre_reset");
        d_rst = {8'h2B, 120'h0123_4567_89AB_CDEF};
        step(1, 1, 8'h80, d_rst, 8'h40, 32'h7, 32'h7);
        chk("in_reset.cmd_out", cmd_out, 128'h0);
        chk("in_reset.ctrl", 128'(ctrl), 128'h0);
        step(0, 0, 0, '0, 8'h40, 32'h7, 32'h7);
        check_model("post_reset");
        step(0, 0, 0, '0, 8'h80, 32'h7, 32'h7);
        chk("reset_write.cmd_out", cmd_out, d_rst);
        chk("reset_write.alu_out", 128'(alu_out), 128'd1);

        // Same-cycle read and write of one address.
        step(0, 1, 8'd3, {32{4'h5}}, 8'd0, 0, 0);
        step(0, 1, 8'd3, {32{4'hA}}, 8'd3, 0, 0);
        chk("collide.cmd_out", cmd_out, WRITE_FIRST ? {32{4'hA}} : {32{4'h5}});
        step(0, 0, 0, '0, 8'd3, 0, 0);
        chk("collide_after.cmd_out", cmd_out, {32{4'hA}});

        for (int i = 0; i < 400; i++) begin
            op = {5'($urandom_range(0, 12)), 3'($urandom)};
            if ($urandom_range(0, 15) == 0) op = 8'($urandom);
            wd = {op, $urandom, $urandom, $urandom, 24'($urandom)};
            a  = pick_operand();
            b  = ($urandom_range(0, 3) == 0) ? a : pick_operand();
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 1) == 1),
                 8'($urandom_range(0, 7)), wd, 8'($urandom_range(0, 7)), a, b);
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_alu_ctrl.md
# cmd_alu_ctrl

Front-end execution slice of the distributed processor. It holds the program command memory, decodes the opcode of the current command into datapath control bits, and provides the combinational ALU. The processor top wraps it with the instruction pointer, register file and qclk, which supply the read address and the ALU operands.

## Interface
- DATA_WIDTH, 32, ALU operand/result width
- CMD_WIDTH, 128, command word width; opcode is cmd_out[CMD_WIDTH-1:CMD_WIDTH-8]
- CMD_ADDR_WIDTH, 8, memory address width; depth is 2**CMD_ADDR_WIDTH
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- write_prog_enable  in  1  program write strobe
- cmd_addr  in  CMD_ADDR_WIDTH  write address
- cmd_data  in  CMD_WIDTH  write data
- read_address  in  CMD_ADDR_WIDTH  read address, from instruction pointer
- cmd_out  out  CMD_WIDTH  registered read data
- alu_in0, alu_in1  in  DATA_WIDTH each  ALU operands, muxed outside
- alu_out  out  DATA_WIDTH  ALU result
- alu_opcode  out  3  decoded ALU op
- c_strobe_enable, alu_in0_sel, alu_in1_sel, reg_write_en, qclk_load_en  out  1 each  control bits
- instr_ptr_en_sel  out  2  00 free-run, 01 wait sync, 10 wait fproc
- instr_ptr_load_en  out  2  00 no load, 01 load, 1x load if alu_out[0]
- sync_out_ready, fproc_out_ready  out  1 each  barrier/fproc request

## Operation
- Memory: write cmd_data to cmd_addr on clk when write_prog_enable is high. The read port is independent of the write port. Contents are not reset and are undefined until written.
- Decode uses opcode[7:3] as the class and opcode[2:0] as the ALU op.
- Decode, by class. Any bit not listed is 0.
  - 00000 NOP: no bits set.
  - 00001 PULSE: c_strobe_enable.
  - 00010 REG_ALU_I: in1_sel=1, reg_write_en.
  - 00011 REG_ALU: in0_sel=1, in1_sel=1, reg_write_en.
  - 00100 JUMP_I: load_en=01.
  - 00101 JUMP_COND_I: in1_sel=1, load_en=10.
  - 00110 JUMP_COND: in0_sel=1, in1_sel=1, load_en=10.
  - 00111 ALU_QCLK_I: qclk_load_en.
  - 01000 ALU_QCLK: in0_sel=1, qclk_load_en.
  - 01001 SYNC: en_sel=01, sync_out_ready.
  - 01010 FPROC: en_sel=10, fproc_out_ready.
  - All other classes decode as NOP.
- alu_opcode equals opcode[2:0] for classes 00010, 00011, 00101 through 01000; otherwise it is 000.
- ALU ops. Results are zero-extended; add and subtract wrap mod 2**DATA_WIDTH.
  - 000: in0
  - 001: in0+in1
  - 010: in0-in1
  - 011: in0==in1
  - 100: in0<in1, signed
  - 101: in0>in1, signed
  - 110: 0
  - 111: in1

## Timing
- cmd_out is registered from read_address with 1-cycle latency.
- The decode outputs and alu_out are purely combinational from cmd_out and the operands, with 0-cycle latency.
- Reset: cmd_out=0 on the next edge, so every control output is 0 and alu_opcode=000. Reset does not touch memory; a write in the same cycle as reset still completes.
- Read and write to the same address in the same cycle: behaviour is set by the Configuration macro.
- Address wrap: the address is exactly CMD_ADDR_WIDTH bits, with no out-of-range case.

## Configuration
- CMD_MEM_WRITE_FIRST_EN:
  - When defined, a simultaneous read and write of the same address returns cmd_data (new data) on cmd_out.
  - When undefined, it returns the previous stored word (read-first).

## Structure
- Shared package `proc_pkg` holds:
  - opcode class constants
  - ALU op constants
  - INST_PTR_DEFAULT_EN=2'b00, INST_PTR_SYNC_EN=2'b01, INST_PTR_FPROC_EN=2'b10
  - OPCODE_WIDTH=8, ALU_OPCODE_WIDTH=3
- Natural sub-modules are `cmd_mem` (the RAM plus output register) and `alu`. The decoder stays inline as a combinational case.

## Test plan
- Write 0x1100...0 to addr 5, then read addr 5 → cmd_out=0x1100...0 one cycle later. Decode gives REG_ALU_I/ADD: alu_opcode=001, in1_sel=1, reg_write_en=1.
- alu_in0=0xFFFFFFFF, alu_in1=2:
  - ADD → 1
  - SUB → 0xFFFFFFFD
  - LT (signed, -1<2) → 1
  - GT → 0
  - EQ → 0
- Opcode 0x20 (JUMP_I) → instr_ptr_load_en=01. Opcode 0x2B (JUMP_COND_I, EQ) with operands 7,7 → load_en=10, alu_out=1.
- Opcode 0x48 → en_sel=01, sync_out_ready=1. Opcode 0x50 → en_sel=10, fproc_out_ready=1. Opcode 0xF8 → all outputs 0.
- Assert reset while cmd_out is non-zero → next edge cmd_out=0 and all control bits are 0. After reset deasserts, the previously written data reads back intact.
- Same-cycle write of 0xAA..A and read at addr 3, which holds 0x55..5 → cmd_out=0xAA..A with CMD_MEM_WRITE_FIRST_EN, 0x55..5 without.
